// File: rtl/usb_rx_rcu_if.sv
// usb_rx_rcu_if: bundle between front end/timer (master: d_edge, eop, shift_en, byte_received, eop_1_comp, eop_comp, address_comp, rcv_data) and the rcu (slave: timer enables, FIFO strobes, packet status)
interface usb_rx_rcu_if;
  logic       d_edge;
  logic       eop;
  logic       shift_en;
  logic       byte_received;
  logic       eop_1_comp;
  logic       eop_comp;
  logic       address_comp;
  logic [7:0] rcv_data;
  logic       rx_transfer_active;
  logic       addr_en;
  logic       eop_en;
  logic       rcving;
  logic       w_enable;
  logic       flush;
  logic       rx_data_ready;
  logic [3:0] rx_packet;
  logic       r_error;
  modport master (
    output d_edge, eop, shift_en, byte_received, eop_1_comp, eop_comp, address_comp, rcv_data,
    input  rx_transfer_active, addr_en, eop_en, rcving, w_enable, flush, rx_data_ready, rx_packet, r_error
  );
  modport slave (
    input  d_edge, eop, shift_en, byte_received, eop_1_comp, eop_comp, address_comp, rcv_data,
    output rx_transfer_active, addr_en, eop_en, rcving, w_enable, flush, rx_data_ready, rx_packet, r_error
  );
endinterface

// File: rtl/usb_rx_rcu.sv
// usb_rx_rcu: USB FS receive control unit; clk/rst plus bus (slave) taking line/timer strobes and driving timer enables, FIFO write/flush and registered packet status
module usb_rx_rcu #(
  parameter int         MAX_BYTES = 66,
  parameter logic [7:0] SYNC_BYTE = 8'h80
) (
  input logic         clk,
  input logic         rst,
  usb_rx_rcu_if.slave bus
);
  typedef enum logic [3:0] {IDLE, SYNC_WAIT, PID_WAIT, ADDR, DATA, EOP_WAIT, DONE, ERR, ERR_IDLE} state_t;
  localparam logic [6:0] CNT_OVF = 7'(MAX_BYTES + 1);
  state_t     state_q, state_d;
  logic       byte_received_q, eop_q;
  logic       bits_pending_q, bits_pending_d;
  logic [6:0] byte_cnt_q, byte_cnt_d;
  logic [3:0] code_q, code_d;
  logic [3:0] pid_code;
  logic       active_q, active_d;
  logic       addr_en_q, addr_en_d;
  logic       eop_en_q, eop_en_d;
  logic       w_enable_q, w_enable_d;
  logic       flush_q, flush_d;
  logic       ready_q, ready_d;
  logic [3:0] packet_q, packet_d;
  logic       r_error_q, r_error_d;
  logic       byte_ev, eop_fall;
  logic [6:0] cnt_inc;
  assign byte_ev  = bus.byte_received & ~byte_received_q;
  assign eop_fall = eop_q & ~bus.eop;
  assign cnt_inc  = byte_cnt_q + 7'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q         <= IDLE;
      byte_received_q <= 1'b0;
      eop_q           <= 1'b0;
      bits_pending_q  <= 1'b0;
      byte_cnt_q      <= 7'd0;
      code_q          <= 4'd0;
      active_q        <= 1'b0;
      addr_en_q       <= 1'b0;
      eop_en_q        <= 1'b0;
      w_enable_q      <= 1'b0;
      flush_q         <= 1'b0;
      ready_q         <= 1'b0;
      packet_q        <= 4'd0;
      r_error_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      byte_received_q <= bus.byte_received;
      eop_q           <= bus.eop;
      bits_pending_q  <= bits_pending_d;
      byte_cnt_q      <= byte_cnt_d;
      code_q          <= code_d;
      active_q        <= active_d;
      addr_en_q       <= addr_en_d;
      eop_en_q        <= eop_en_d;
      w_enable_q      <= w_enable_d;
      flush_q         <= flush_d;
      ready_q         <= ready_d;
      packet_q        <= packet_d;
      r_error_q       <= r_error_d;
    end
  always_comb begin
    pid_code = 4'd0;
    if (bus.rcv_data[3:0] == ~bus.rcv_data[7:4])
      case (bus.rcv_data[3:0])
        4'b0001: pid_code = 4'd1;
        4'b1001: pid_code = 4'd2;
        4'b1101: pid_code = 4'd3;
        4'b0011: pid_code = 4'd4;
        4'b1011: pid_code = 4'd5;
        4'b0010: pid_code = 4'd6;
        4'b1010: pid_code = 4'd7;
        4'b1110: pid_code = 4'd8;
        default: pid_code = 4'd0;
      endcase
    bits_pending_d = byte_ev ? 1'b0 : bus.shift_en ? 1'b1 : bits_pending_q;
    byte_cnt_d     = state_q != DATA ? 7'd0 : byte_ev ? cnt_inc : byte_cnt_q;
    code_d         = state_q == PID_WAIT && byte_ev ? pid_code : code_q;
    state_d        = state_q;
    case (state_q)
      IDLE:      if (bus.d_edge) state_d = SYNC_WAIT;
      SYNC_WAIT: if (byte_ev) state_d = bus.rcv_data == SYNC_BYTE ? PID_WAIT : ERR;
      PID_WAIT:  if (byte_ev) state_d = pid_code == 4'd0 ? ERR : pid_code <= 4'd3 ? ADDR : pid_code <= 4'd5 ? DATA : EOP_WAIT;
      ADDR:      state_d = bus.address_comp ? EOP_WAIT : bus.eop ? ERR : ADDR;
      DATA:
        if (byte_ev) state_d = cnt_inc == CNT_OVF ? ERR : DATA;
        else if (bus.eop) state_d = bits_pending_q || byte_cnt_q < 7'd2 ? ERR : EOP_WAIT;
      EOP_WAIT:  state_d = bus.eop_comp ? DONE : byte_ev || eop_fall ? ERR : EOP_WAIT;
      DONE:      state_d = IDLE;
      ERR:       if (bus.eop_comp) state_d = ERR_IDLE;
      ERR_IDLE:  if (bus.d_edge) state_d = SYNC_WAIT;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    active_d   = !(state_d inside {IDLE, ERR_IDLE});
    addr_en_d  = state_d == ADDR;
    eop_en_d   = (state_d inside {EOP_WAIT, ERR}) && bus.eop;
    w_enable_d = state_q == DATA && byte_ev && cnt_inc != CNT_OVF;
    flush_d    = state_q == PID_WAIT && state_d == DATA;
    ready_d    = state_d == DONE;
    packet_d   = state_d == DONE ? code_q : 4'd0;
    r_error_d  = state_d inside {ERR, ERR_IDLE};
  end
  assign bus.rx_transfer_active = active_q;
  assign bus.rcving             = active_q;
  assign bus.addr_en            = addr_en_q;
  assign bus.eop_en             = eop_en_q;
  assign bus.w_enable           = w_enable_q;
  assign bus.flush              = flush_q;
  assign bus.rx_data_ready      = ready_q;
  assign bus.rx_packet          = packet_q;
  assign bus.r_error            = r_error_q;
endmodule
